// File: rtl/cu_sequencer_if.sv
// Control-unit bundle: datapath opcode/function fields and memory handshake in,
// datapath control strobes and sequencer status out.
interface cu_sequencer_if;
  logic       start;
  logic       step;
  logic [3:0] instIn;
  logic [7:0] funcIn;
  logic       memReady;

  logic       rstPC;
  logic       ldPC;
  logic       pcSel;
  logic       branchSel;
  logic       jumpSel;
  logic       regSel;
  logic       inSel;
  logic       selDm;
  logic       selALU;
  logic       regWrite;
  logic       nop;
  logic       ldWnd;
  logic       memWrite;
  logic       memRead;
  logic [1:0] wndCtrl;
  logic [2:0] funcCtrl;
  logic       busy;
  logic       halted;
  logic       retired;
  logic [1:0] error;

  modport slave (
    input  start, step, instIn, funcIn, memReady,
    output rstPC, ldPC, pcSel, branchSel, jumpSel, regSel, inSel, selDm, selALU,
           regWrite, nop, ldWnd, memWrite, memRead, wndCtrl, funcCtrl,
           busy, halted, retired, error
  );

  modport master (
    output start, step, instIn, funcIn, memReady,
    input  rstPC, ldPC, pcSel, branchSel, jumpSel, regSel, inSel, selDm, selALU,
           regWrite, nop, ldWnd, memWrite, memRead, wndCtrl, funcCtrl,
           busy, halted, retired, error
  );
endinterface

// File: rtl/cu_sequencer.sv
// Instruction sequencer: decodes one instruction per RUN cycle, stalls in MEMWAIT for
// loads/stores with a timeout, and parks in HALT. Optional macro CU_STEP_EN gates RUN on step.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | PC held in reset, waiting for start
// RUN     | decode instIn/funcIn; non-memory ops retire this cycle
// MEMWAIT | LOAD/STORE in flight, waiting for memReady or timeout
// HALT    | stopped (HALT op, illegal op or timeout) until rst
module cu_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  cu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_MEMWAIT = 2'd2,
    S_HALT    = 2'd3
  } state_e;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_BRZ   = 4'b0100;
  localparam logic [3:0] OP_WND   = 4'b0110;
  localparam logic [3:0] OP_RTYPE = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1100;
  localparam logic [3:0] OP_SUBI  = 4'b1101;
  localparam logic [3:0] OP_ANDI  = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [2:0] FN_MOV = 3'b000;
  localparam logic [2:0] FN_ADD = 3'b001;
  localparam logic [2:0] FN_SUB = 3'b010;
  localparam logic [2:0] FN_AND = 3'b011;
  localparam logic [2:0] FN_OR  = 3'b100;
  localparam logic [2:0] FN_NOT = 3'b101;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Counter value seen during the last permitted MEMWAIT cycle (counter starts at 0).
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       is_store_q, is_store_d;
  logic [1:0] error_q, error_d;

  logic exec_en;
  logic retire;
  logic jump_sel;
  logic branch_sel;
  logic unused_ok;

`ifdef CU_STEP_EN
  assign exec_en   = bus.step;
  assign unused_ok = ^bus.funcIn[7:6];
`else
  assign exec_en   = 1'b1;
  assign unused_ok = ^{bus.step, bus.funcIn[7:6]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      is_store_q <= 1'b0;
      error_q    <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      is_store_q <= is_store_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    is_store_d    = is_store_q;
    error_d       = error_q;
    retire        = 1'b0;
    jump_sel      = 1'b0;
    branch_sel    = 1'b0;
    bus.rstPC     = 1'b0;
    bus.regSel    = 1'b0;
    bus.inSel     = 1'b0;
    bus.selDm     = 1'b0;
    bus.selALU    = 1'b0;
    bus.regWrite  = 1'b0;
    bus.nop       = 1'b0;
    bus.ldWnd     = 1'b0;
    bus.memWrite  = 1'b0;
    bus.memRead   = 1'b0;
    bus.wndCtrl   = 2'b00;
    bus.funcCtrl  = FN_MOV;
    bus.busy      = 1'b0;
    bus.halted    = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.rstPC = 1'b1;
        bus.nop   = 1'b1;
        if (bus.start) state_d = S_RUN;
      end

      S_RUN: begin
        bus.busy = 1'b1;
        if (!exec_en) begin
          bus.nop = 1'b1;
        end else begin
          case (bus.instIn)
            OP_RTYPE: begin
              retire = 1'b1;
              if (bus.funcIn[5:0] == 6'd0) begin
                bus.nop = 1'b1;
              end else begin
                bus.regSel   = 1'b1;
                bus.selALU   = 1'b1;
                bus.regWrite = 1'b1;
                // Lowest set function bit selects the ALU operation.
                if      (bus.funcIn[0]) bus.funcCtrl = FN_ADD;
                else if (bus.funcIn[1]) bus.funcCtrl = FN_SUB;
                else if (bus.funcIn[2]) bus.funcCtrl = FN_AND;
                else if (bus.funcIn[3]) bus.funcCtrl = FN_OR;
                else if (bus.funcIn[4]) bus.funcCtrl = FN_NOT;
                else                    bus.funcCtrl = FN_MOV;
              end
            end
            OP_ADDI, OP_SUBI, OP_ANDI: begin
              retire       = 1'b1;
              bus.inSel    = 1'b1;
              bus.selALU   = 1'b1;
              bus.regWrite = 1'b1;
              bus.funcCtrl = (bus.instIn == OP_ADDI) ? FN_ADD :
                             (bus.instIn == OP_SUBI) ? FN_SUB : FN_AND;
            end
            OP_JUMP: begin
              retire   = 1'b1;
              jump_sel = 1'b1;
            end
            OP_BRZ: begin
              retire       = 1'b1;
              branch_sel   = 1'b1;
              bus.regSel   = 1'b1;
              bus.funcCtrl = FN_SUB;
            end
            OP_WND: begin
              retire      = 1'b1;
              bus.ldWnd   = 1'b1;
              bus.wndCtrl = bus.funcIn[1:0];
            end
            OP_LOAD, OP_STORE: begin
              bus.nop    = 1'b1;
              state_d    = S_MEMWAIT;
              wait_cnt_d = '0;
              is_store_d = (bus.instIn == OP_STORE);
            end
            OP_HALT: begin
              bus.nop = 1'b1;
              state_d = S_HALT;
              error_d = ERR_NONE;
            end
            default: begin
              bus.nop = 1'b1;
              state_d = S_HALT;
              error_d = ERR_ILLEGAL;
            end
          endcase
        end
      end

      S_MEMWAIT: begin
        bus.busy     = 1'b1;
        bus.memWrite = is_store_q;
        bus.memRead  = ~is_store_q;
        wait_cnt_d   = wait_cnt_q + 8'd1;
        // memReady on the final allowed cycle still completes the access.
        if (bus.memReady) begin
          retire       = 1'b1;
          bus.selDm    = ~is_store_q;
          bus.regWrite = ~is_store_q;
          state_d      = S_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          bus.nop = 1'b1;
          state_d = S_HALT;
          error_d = ERR_TIMEOUT;
        end else begin
          bus.nop = 1'b1;
        end
      end

      S_HALT: begin
        bus.nop    = 1'b1;
        bus.halted = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase

    bus.ldPC      = retire;
    bus.retired   = retire;
    bus.jumpSel   = jump_sel;
    bus.branchSel = branch_sel;
    bus.pcSel     = retire & ~jump_sel & ~branch_sel;
    bus.error     = error_q;
  end

endmodule

// File: tb/tb_cu_sequencer.sv
// Scoreboard bench for cu_sequencer: each cycle's expected control vector is queued when
// stimulus is driven and popped against the sampled outputs mid-cycle.
module tb_cu_sequencer;
  localparam int MEM_TO = 4;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_BRZ   = 4'b0100;
  localparam logic [3:0] OP_WND   = 4'b0110;
  localparam logic [3:0] OP_R     = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1100;
  localparam logic [3:0] OP_SUBI  = 4'b1101;
  localparam logic [3:0] OP_ANDI  = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cu_sequencer_if bus();

  cu_sequencer #(.MEM_TIMEOUT(MEM_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rstPC, ldPC, pcSel, branchSel, jumpSel, regSel, inSel, selDm;
    logic       selALU, regWrite, nop, ldWnd, memWrite, memRead;
    logic [1:0] wndCtrl;
    logic [2:0] funcCtrl;
    logic       busy, halted, retired;
    logic [1:0] error;
  } ctl_t;

  typedef struct packed {
    logic       chk, rst, start, stp;
    logic [3:0] op;
    logic [7:0] f;
    logic       rdy;
    ctl_t       exp;
  } cyc_t;

  ctl_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  function automatic ctl_t m_idle();
    ctl_t c = '0;
    c.rstPC = 1'b1;
    c.nop   = 1'b1;
    return c;
  endfunction

  function automatic ctl_t m_halt(input logic [1:0] e);
    ctl_t c = '0;
    c.nop    = 1'b1;
    c.halted = 1'b1;
    c.error  = e;
    return c;
  endfunction

  function automatic ctl_t m_run(input logic [3:0] op, input logic [7:0] f, input logic stp);
    ctl_t c = '0;
    logic gate;
`ifdef CU_STEP_EN
    gate = stp;
`else
    gate = stp | 1'b1;
`endif
    c.busy = 1'b1;
    if (!gate) begin
      c.nop = 1'b1;
      return c;
    end
    case (op)
      OP_R: begin
        c.ldPC = 1'b1; c.pcSel = 1'b1; c.retired = 1'b1;
        if (f[5:0] == 6'd0) c.nop = 1'b1;
        else begin
          c.regSel = 1'b1; c.selALU = 1'b1; c.regWrite = 1'b1;
          for (int b = 5; b >= 0; b--)
            if (f[b]) c.funcCtrl = (b == 5) ? 3'b000 : 3'(b + 1);
        end
      end
      OP_ADDI, OP_SUBI, OP_ANDI: begin
        c.ldPC = 1'b1; c.pcSel = 1'b1; c.retired = 1'b1;
        c.inSel = 1'b1; c.selALU = 1'b1; c.regWrite = 1'b1;
        c.funcCtrl = 3'(op[1:0] + 2'd1);
      end
      OP_JUMP: begin
        c.ldPC = 1'b1; c.retired = 1'b1; c.jumpSel = 1'b1;
      end
      OP_BRZ: begin
        c.ldPC = 1'b1; c.retired = 1'b1; c.branchSel = 1'b1;
        c.regSel = 1'b1; c.funcCtrl = 3'b010;
      end
      OP_WND: begin
        c.ldPC = 1'b1; c.pcSel = 1'b1; c.retired = 1'b1;
        c.ldWnd = 1'b1; c.wndCtrl = f[1:0];
      end
      default: c.nop = 1'b1;
    endcase
    return c;
  endfunction

  function automatic ctl_t m_mem(input logic st, input logic rdy);
    ctl_t c = '0;
    c.busy     = 1'b1;
    c.memWrite = st;
    c.memRead  = !st;
    if (rdy) begin
      c.ldPC = 1'b1; c.pcSel = 1'b1; c.retired = 1'b1;
      c.selDm = !st; c.regWrite = !st;
    end else begin
      c.nop = 1'b1;
    end
    return c;
  endfunction

  function automatic cyc_t cy(input ctl_t e, input logic [3:0] op, input logic [7:0] f,
                              input logic rdy, input logic start, input logic r,
                              input logic stp, input logic chk);
    cyc_t c;
    c.exp = e; c.op = op; c.f = f; c.rdy = rdy;
    c.start = start; c.rst = r; c.stp = stp; c.chk = chk;
    return c;
  endfunction

  function automatic ctl_t sample();
    ctl_t c;
    c.rstPC = bus.rstPC; c.ldPC = bus.ldPC; c.pcSel = bus.pcSel;
    c.branchSel = bus.branchSel; c.jumpSel = bus.jumpSel; c.regSel = bus.regSel;
    c.inSel = bus.inSel; c.selDm = bus.selDm; c.selALU = bus.selALU;
    c.regWrite = bus.regWrite; c.nop = bus.nop; c.ldWnd = bus.ldWnd;
    c.memWrite = bus.memWrite; c.memRead = bus.memRead; c.wndCtrl = bus.wndCtrl;
    c.funcCtrl = bus.funcCtrl; c.busy = bus.busy; c.halted = bus.halted;
    c.retired = bus.retired; c.error = bus.error;
    return c;
  endfunction

  task automatic drive_cycle(input cyc_t c);
    @(posedge clk);
    #1;
    rst          = c.rst;
    bus.start    = c.start;
    bus.step     = c.stp;
    bus.instIn   = c.op;
    bus.funcIn   = c.f;
    bus.memReady = c.rdy;
    if (c.chk) sb_q.push_back(c.exp);
  endtask

  // Two reset cycles (first unchecked: prior state unknown to this task) then start.
  task automatic preamble(output cyc_t p[3]);
    p[0] = cy(m_idle(), OP_R, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    p[1] = cy(m_idle(), OP_R, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    p[2] = cy(m_idle(), OP_R, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    cyc_t seq[$];
    ctl_t got, exp;
    seq.push_back(cy(m_idle(), OP_R, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    seq.push_back(cy(m_idle(), OP_R, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    seq.push_back(cy(m_idle(), OP_R, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_idle(), OP_R, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    foreach (seq[i]) begin
      drive_cycle(seq[i]);
      @(negedge clk);
      if (seq[i].chk) begin
        exp = sb_q.pop_front();
        got = sample();
        n_total++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL reset[%0d] got=%h expected=%h", i, got, exp);
        end
      end
    end
  endtask

  task automatic test_rtype();
    cyc_t seq[$];
    cyc_t p[3];
    ctl_t got, exp;
    logic [7:0] fl[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h00, 8'h06, 8'hC0, 8'h30};
    preamble(p);
    foreach (p[k]) seq.push_back(p[k]);
    foreach (fl[k]) seq.push_back(cy(m_run(OP_R, fl[k], 1'b1), OP_R, fl[k], 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    foreach (seq[i]) begin
      drive_cycle(seq[i]);
      @(negedge clk);
      if (seq[i].chk) begin
        exp = sb_q.pop_front();
        got = sample();
        n_total++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL rtype[%0d] func=%h got=%h expected=%h", i, seq[i].f, got, exp);
        end
      end
    end
  endtask

  task automatic test_imm_ctrl();
    cyc_t seq[$];
    cyc_t p[3];
    ctl_t got, exp;
    logic [3:0] ops[7] = '{OP_ADDI, OP_SUBI, OP_ANDI, OP_JUMP, OP_BRZ, OP_WND, OP_WND};
    logic [7:0] fs[7]  = '{8'h55, 8'hAA, 8'h0F, 8'h3C, 8'h00, 8'h03, 8'hF2};
    preamble(p);
    foreach (p[k]) seq.push_back(p[k]);
    foreach (ops[k]) seq.push_back(cy(m_run(ops[k], fs[k], 1'b1), ops[k], fs[k], 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_run(OP_HALT, 8'h00, 1'b1), OP_HALT, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_halt(2'b00), OP_HALT, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_halt(2'b00), OP_R, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
    foreach (seq[i]) begin
      drive_cycle(seq[i]);
      @(negedge clk);
      if (seq[i].chk) begin
        exp = sb_q.pop_front();
        got = sample();
        n_total++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL imm_ctrl[%0d] op=%b got=%h expected=%h", i, seq[i].op, got, exp);
        end
      end
    end
  endtask

  task automatic test_load_store();
    cyc_t seq[$];
    cyc_t p[3];
    ctl_t got, exp;
    preamble(p);
    foreach (p[k]) seq.push_back(p[k]);
    // LOAD, memReady on third wait cycle
    seq.push_back(cy(m_run(OP_LOAD, 8'h00, 1'b1), OP_LOAD, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_mem(1'b0, 1'b0), OP_LOAD, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_mem(1'b0, 1'b0), OP_LOAD, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_mem(1'b0, 1'b1), OP_LOAD, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_run(OP_ADDI, 8'h00, 1'b1), OP_ADDI, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    // STORE, ready at once
    seq.push_back(cy(m_run(OP_STORE, 8'h00, 1'b1), OP_STORE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_mem(1'b1, 1'b1), OP_STORE, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_run(OP_JUMP, 8'h00, 1'b1), OP_JUMP, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    // STORE, ready exactly on the timeout cycle: completes, no error
    seq.push_back(cy(m_run(OP_STORE, 8'h00, 1'b1), OP_STORE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    for (int k = 0; k < MEM_TO - 1; k++)
      seq.push_back(cy(m_mem(1'b1, 1'b0), OP_STORE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_mem(1'b1, 1'b1), OP_STORE, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_run(OP_R, 8'h08, 1'b1), OP_R, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    foreach (seq[i]) begin
      drive_cycle(seq[i]);
      @(negedge clk);
      if (seq[i].chk) begin
        exp = sb_q.pop_front();
        got = sample();
        n_total++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL load_store[%0d] got=%h expected=%h", i, got, exp);
        end
      end
    end
  endtask

  task automatic test_timeout();
    cyc_t seq[$];
    cyc_t p[3];
    ctl_t got, exp;
    preamble(p);
    foreach (p[k]) seq.push_back(p[k]);
    seq.push_back(cy(m_run(OP_STORE, 8'h00, 1'b1), OP_STORE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    for (int k = 0; k < MEM_TO; k++)
      seq.push_back(cy(m_mem(1'b1, 1'b0), OP_STORE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_halt(2'b10), OP_STORE, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_halt(2'b10), OP_R, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
    foreach (seq[i]) begin
      drive_cycle(seq[i]);
      @(negedge clk);
      if (seq[i].chk) begin
        exp = sb_q.pop_front();
        got = sample();
        n_total++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL timeout[%0d] got=%h expected=%h", i, got, exp);
        end
      end
    end
  endtask

  task automatic test_illegal();
    cyc_t seq[$];
    ctl_t got, exp;
    logic [3:0] ill[7] = '{4'b0011, 4'b0101, 4'b0111, 4'b1001, 4'b1010, 4'b1011, 4'b0011};
    seq.push_back(cy(m_idle(), OP_R, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    seq.push_back(cy(m_idle(), OP_R, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    foreach (ill[k]) begin
      seq.push_back(cy(m_idle(), OP_R, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
      seq.push_back(cy(m_run(ill[k], 8'h3F, 1'b1), ill[k], 8'h3F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
      seq.push_back(cy(m_halt(2'b01), OP_R, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
      seq.push_back(cy(m_halt(2'b01), OP_R, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
      seq.push_back(cy(m_idle(), OP_R, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    end
    foreach (seq[i]) begin
      drive_cycle(seq[i]);
      @(negedge clk);
      if (seq[i].chk) begin
        exp = sb_q.pop_front();
        got = sample();
        n_total++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL illegal[%0d] op=%b got=%h expected=%h", i, seq[i].op, got, exp);
        end
      end
    end
  endtask

  task automatic test_reset_midwait();
    cyc_t seq[$];
    cyc_t p[3];
    ctl_t got, exp;
    preamble(p);
    foreach (p[k]) seq.push_back(p[k]);
    seq.push_back(cy(m_run(OP_LOAD, 8'h00, 1'b1), OP_LOAD, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_mem(1'b0, 1'b0), OP_LOAD, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_mem(1'b0, 1'b0), OP_LOAD, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
    seq.push_back(cy(m_idle(), OP_LOAD, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_idle(), OP_LOAD, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    foreach (seq[i]) begin
      drive_cycle(seq[i]);
      @(negedge clk);
      if (seq[i].chk) begin
        exp = sb_q.pop_front();
        got = sample();
        n_total++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL reset_midwait[%0d] got=%h expected=%h", i, got, exp);
        end
      end
    end
  endtask

  task automatic test_step();
    cyc_t seq[$];
    cyc_t p[3];
    ctl_t got, exp;
    int   n_ret = 0;
    int   exp_ret;
    int   lo, hi;
    preamble(p);
    foreach (p[k]) seq.push_back(p[k]);
`ifdef CU_STEP_EN
    for (int k = 0; k < 5; k++)
      seq.push_back(cy(m_run(OP_ADDI, 8'h00, 1'b0), OP_ADDI, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    seq.push_back(cy(m_run(OP_ADDI, 8'h00, 1'b1), OP_ADDI, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    lo = 3; hi = 8; exp_ret = 1;
    seq.push_back(cy(m_run(OP_LOAD, 8'h00, 1'b0), OP_LOAD, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    seq.push_back(cy(m_run(OP_LOAD, 8'h00, 1'b1), OP_LOAD, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    seq.push_back(cy(m_mem(1'b0, 1'b0), OP_LOAD, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    seq.push_back(cy(m_mem(1'b0, 1'b1), OP_LOAD, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
`else
    for (int k = 0; k < 3; k++)
      seq.push_back(cy(m_run(OP_SUBI, 8'h00, 1'b0), OP_SUBI, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    lo = 3; hi = 5; exp_ret = 3;
    seq.push_back(cy(m_run(OP_WND, 8'h01, 1'b0), OP_WND, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
`endif
    foreach (seq[i]) begin
      drive_cycle(seq[i]);
      @(negedge clk);
      if (i >= lo && i <= hi && bus.retired === 1'b1) n_ret++;
      if (seq[i].chk) begin
        exp = sb_q.pop_front();
        got = sample();
        n_total++;
        if (got !== exp) begin
          n_bad++;
          $display("FAIL step[%0d] got=%h expected=%h", i, got, exp);
        end
      end
    end
    n_total++;
    if (n_ret != exp_ret) begin
      n_bad++;
      $display("FAIL step_retire_count got=%0d expected=%0d", n_ret, exp_ret);
    end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.step     = 1'b1;
    bus.instIn   = OP_R;
    bus.funcIn   = 8'h00;
    bus.memReady = 1'b0;
    test_reset();
    test_rtype();
    test_imm_ctrl();
    test_load_store();
    test_timeout();
    test_illegal();
    test_reset_midwait();
    test_step();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
